modulo_entrada: RTL and testbench
=================================

Name: modulo_entrada

Overview:
- Input-side peripheral; the counterpart of the output module.
- Serves the processor's IN instruction: on a CPU request it waits for an operator key press, then hands the switch value to the CPU as a 32-bit word.
- Contains a synchronizer and debouncer for the raw key, an edge detector, and a request/ready handshake FSM.
- Sits beside the processor in the system top, driven by the same switches (dadosIN) and key (chave).

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a key level change is accepted; legal range 2..2^20.
- DATA_W, 8: switch bus width.
- OUT_W, 32: width of the word returned to the CPU; must satisfy OUT_W > DATA_W.

Ports:
- realClk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- chave  input  1  raw pushbutton, asynchronous, active-low (0 = pressed).
- dadosIN  input  DATA_W  switch value, sampled only at capture.
- pedido  input  1  CPU request level, high while an IN instruction is stalled.
- dado  output  OUT_W  captured word, held until the next capture.
- pronto  output  1  single-cycle pulse; dado is valid in that cycle and after it.
- aguardando  output  1  high while waiting for the operator (status LED).

Behaviour:
Reset (rst=0 at a realClk edge):
- FSM goes to OCIOSO; dado=0, pronto=0, aguardando=0.
- Synchronizer flops are set to 1, the debounced level to 1 (released), and the debounce counter to 0.

Debounce:
- chave passes through 2 flops (sync2).
- If sync2 equals the stable level, the counter clears.
- Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the stable level toggles and the counter clears.
- Press latency from a clean chave edge to the stable level changing: DEBOUNCE_CYCLES+2 cycles.
- evt_press is a one-cycle pulse on a stable 1->0 transition.
- evt_release is a one-cycle pulse on a stable 0->1 transition.

FSM:
- OCIOSO: if pedido=1, go to ESPERA. Presses are ignored in this state; they are not buffered.
- ESPERA: aguardando=1. On evt_press, go to CAPTURA. A key already held when ESPERA is entered does not count; a fresh 1->0 edge is required.
- CAPTURA (one cycle):
  - dado <= dadosIN, zero-extended to OUT_W (see optional feature).
  - pronto=1 during this cycle only.
  - Next state: LIBERA.
- LIBERA: wait until the stable level is released and pedido=0, in either order or simultaneously, then go to OCIOSO. This prevents one press from serving two IN instructions.

Timing and boundary rules:
- pronto asserts 1 cycle after the cycle in which evt_press occurs.
- dado updates on the same edge that raises pronto.
- pedido dropping during ESPERA (CPU aborted): return to OCIOSO next cycle; no capture, dado unchanged.
- pedido still high in LIBERA after release: stay in LIBERA, never re-capture. The CPU must drop pedido after seeing pronto.
- Reset during any state: takes effect on the next edge; any pending capture is lost and pronto does not fire.
- Key bounce shorter than DEBOUNCE_CYCLES consecutive cycles never changes the stable level.
- Counter width is ceil(log2(DEBOUNCE_CYCLES)) and it never wraps.

Optional Feature:
- Macro: MODULO_ENTRADA_SINAL_EN.
- Defined: capture sign-extends, so dado[OUT_W-1:DATA_W] = dadosIN[DATA_W-1]. Example: switches 8'h9C give dado=32'hFFFFFF9C.
- Undefined (default): capture zero-extends, so 8'h9C gives dado=32'h0000009C.
- The feature has no other effect.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Basic handshake: rst low 2 cycles then high; pedido=1; dadosIN=8'h5A; chave 1->0 clean -> aguardando=1 from cycle after pedido; pronto pulses exactly once, 7 cycles after the chave edge; dado=32'h0000005A.
- Bounce rejection: in ESPERA, chave toggles every 2 cycles for 20 cycles, then holds 0 -> no pronto during toggling; exactly one pronto after the hold.
- Held-key and double-serve guard: key held before pedido rises -> no capture until release plus a fresh press. After a capture, keep the key held, drop pedido, raise pedido again -> no second pronto until release and re-press.
- Abort: pedido=1, then 0 after 3 cycles with no press -> FSM returns to OCIOSO, aguardando=0, dado keeps its previous value 32'h0000005A.
- Reset mid-operation: assert rst during ESPERA on the same edge as evt_press -> pronto stays 0, dado=0, FSM in OCIOSO.
- Optional feature: with MODULO_ENTRADA_SINAL_EN defined, capture dadosIN=8'h9C -> dado=32'hFFFFFF9C. Without the macro -> dado=32'h0000009C.

Source files
------------

// File: rtl/modulo_entrada.sv
// rtl/modulo_entrada.sv - IN-instruction input peripheral: key debounce plus request/ready capture FSM (optional sign extension: MODULO_ENTRADA_SINAL_EN)
module modulo_entrada #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DATA_W          = 8,
    parameter int OUT_W           = 32
) (
    input  logic              realClk,
    input  logic              rst,
    input  logic              chave,
    input  logic [DATA_W-1:0] dadosIN,
    input  logic              pedido,
    output logic [OUT_W-1:0]  dado,
    output logic              pronto,
    output logic              aguardando
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        CAPTURA = 2'd2,
        LIBERA  = 2'd3
    } estado_t;

    estado_t          estado;
    estado_t          estado_prox;
    logic             sync1;
    logic             sync2;
    logic             estavel;
    logic             estavel_q;
    logic [CW-1:0]    cnt;
    logic             evt_press;
    logic             captura;
    logic [OUT_W-1:0] estendido;

    // Two-flop synchronizer for the asynchronous key; idles at released (1)
    always_ff @(posedge realClk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= chave;
            sync2 <= sync1;
        end
    end

    // Debounce: the stable level only follows sync2 after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge realClk) begin
        if (!rst) begin
            estavel   <= 1'b1;
            estavel_q <= 1'b1;
            cnt       <= '0;
        end else begin
            estavel_q <= estavel;
            if (sync2 == estavel) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                estavel <= ~estavel;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // A press event is the stable level falling; a key already held never produces one
    assign evt_press = estavel_q & ~estavel;

    // Abort takes priority over a press arriving in the same cycle
    assign captura = (estado == ESPERA) && pedido && evt_press;

`ifdef MODULO_ENTRADA_SINAL_EN
    assign estendido = {{(OUT_W-DATA_W){dadosIN[DATA_W-1]}}, dadosIN};
`else
    assign estendido = {{(OUT_W-DATA_W){1'b0}}, dadosIN};
`endif

    // FSM state register
    always_ff @(posedge realClk) begin
        if (!rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic and Moore outputs; pronto is exactly the single CAPTURA cycle
    always_comb begin
        estado_prox = estado;
        pronto      = 1'b0;
        aguardando  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (pedido) begin
                    estado_prox = ESPERA;
                end
            end
            ESPERA: begin
                aguardando = 1'b1;
                if (!pedido) begin
                    estado_prox = OCIOSO;
                end else if (evt_press) begin
                    estado_prox = CAPTURA;
                end
            end
            CAPTURA: begin
                pronto      = 1'b1;
                estado_prox = LIBERA;
            end
            LIBERA: begin
                // Both the key and the request must be released so one press serves one IN
                if (estavel && !pedido) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Captured word is loaded on the edge that enters CAPTURA and held until the next capture
    always_ff @(posedge realClk) begin
        if (!rst) begin
            dado <= '0;
        end else if (captura) begin
            dado <= estendido;
        end
    end

endmodule

// File: tb/tb_modulo_entrada.sv
// tb/tb_modulo_entrada.sv - scoreboard testbench for modulo_entrada
module tb_modulo_entrada;

    localparam int DEB = 4;

    logic        realClk;
    logic        rst;
    logic        chave;
    logic [7:0]  dadosIN;
    logic        pedido;
    logic [31:0] dado;
    logic        pronto;
    logic        aguardando;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          fails;
    int          cyc;
    logic [31:0] last_dado;

    modulo_entrada #(
        .DEBOUNCE_CYCLES(DEB),
        .DATA_W(8),
        .OUT_W(32)
    ) dut (
        .realClk(realClk),
        .rst(rst),
        .chave(chave),
        .dadosIN(dadosIN),
        .pedido(pedido),
        .dado(dado),
        .pronto(pronto),
        .aguardando(aguardando)
    );

    initial realClk = 1'b0;
    always #5 realClk = ~realClk;

    always @(posedge realClk) cyc <= cyc + 1;

    function automatic logic [31:0] modelo_ext(input int v);
`ifdef MODULO_ENTRADA_SINAL_EN
        if (v >= 128) return 32'(v - 256);
`endif
        return 32'(v);
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nome, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge realClk);
        #1;
    endtask

    // Model: a press held for at least DEB cycles in ESPERA yields one capture, DEB+3 cycles after the edge
    task automatic press_expect(input string nome);
        exp_t e;
        chave  = 1'b0;
        e.d    = modelo_ext(int'(dadosIN));
        e.c    = cyc + DEB + 3;
        sb.push_back(e);
        last_dado = e.d;
        wait_drain(40, nome);
    endtask

    task automatic wait_drain(input int budget, input string nome);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s: no pronto within %0d cycles, required one", nome, budget);
            sb.delete();
        end
    endtask

    // Monitor: every pronto must match the oldest expected capture
    always @(negedge realClk) begin
        if (pronto === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pronto: got pronto=1 dado=%h at cycle %0d, required pronto=0", dado, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("capture_dado", dado, e.d);
                if (e.c >= 0) chk("pronto_latency", 32'(cyc), 32'(e.c));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge realClk);
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        chave   = 1'b1;
        pedido  = 1'b0;
        dadosIN = 8'h00;
        last_dado = 32'h0;
        tick(2);
        chk("reset_dado", dado, 32'h0);
        chk("reset_pronto", 32'(pronto), 32'h0);
        chk("reset_aguardando", 32'(aguardando), 32'h0);
        rst = 1'b1;
        tick(1);

        // Basic handshake
        dadosIN = 8'h5A;
        pedido  = 1'b1;
        tick(1);
        chk("basic_aguardando", 32'(aguardando), 32'h1);
        press_expect("basic");
        chk("basic_dado_hold", dado, 32'h0000005A);
        chk("basic_libera_aguardando", 32'(aguardando), 32'h0);
        chave  = 1'b1;
        pedido = 1'b0;
        tick(8);

        // Abort without a press; then presses while idle are ignored
        pedido = 1'b1;
        tick(3);
        chk("abort_aguardando_on", 32'(aguardando), 32'h1);
        pedido = 1'b0;
        tick(1);
        chk("abort_aguardando_off", 32'(aguardando), 32'h0);
        chk("abort_dado_kept", dado, last_dado);
        chave = 1'b0;
        tick(8);
        chave = 1'b1;
        tick(8);

        // Bounce rejection
        dadosIN = 8'($urandom_range(0, 255));
        pedido  = 1'b1;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            chave = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        chk("bounce_still_waiting", 32'(aguardando), 32'h1);
        press_expect("bounce");
        chave  = 1'b1;
        pedido = 1'b0;
        tick(8);

        // Held key before request, then double-serve guard
        chave = 1'b0;
        tick(10);
        pedido = 1'b1;
        tick(10);
        chk("held_no_capture", 32'(aguardando), 32'h1);
        chave = 1'b1;
        tick(8);
        chk("held_release_waiting", 32'(aguardando), 32'h1);
        dadosIN = 8'($urandom_range(0, 255));
        press_expect("fresh_press");
        pedido = 1'b0;
        tick(3);
        pedido = 1'b1;
        tick(10);
        chk("guard_held_libera", 32'(aguardando), 32'h0);
        chave = 1'b1;
        tick(10);
        chk("guard_pedido_high_libera", 32'(aguardando), 32'h0);
        pedido = 1'b0;
        tick(1);
        pedido = 1'b1;
        tick(1);
        chk("guard_rearmed", 32'(aguardando), 32'h1);
        dadosIN = 8'($urandom_range(0, 255));
        press_expect("repress");
        chave  = 1'b1;
        pedido = 1'b0;
        tick(8);

        // Extension of a negative switch value
        dadosIN = 8'h9C;
        pedido  = 1'b1;
        tick(1);
        press_expect("ext_9c");
`ifdef MODULO_ENTRADA_SINAL_EN
        chk("ext_9c_value", dado, 32'hFFFFFF9C);
`else
        chk("ext_9c_value", dado, 32'h0000009C);
`endif
        chave  = 1'b1;
        pedido = 1'b0;
        tick(8);

        // Reset on the same edge that would take the press
        pedido  = 1'b1;
        dadosIN = 8'hA5;
        tick(1);
        chave = 1'b0;
        tick(DEB + 2);
        chk("rstmid_waiting", 32'(aguardando), 32'h1);
        rst    = 1'b0;
        pedido = 1'b0;
        tick(1);
        chk("rstmid_pronto", 32'(pronto), 32'h0);
        chk("rstmid_dado", dado, 32'h0);
        chk("rstmid_aguardando", 32'(aguardando), 32'h0);
        last_dado = 32'h0;
        rst   = 1'b1;
        chave = 1'b1;
        tick(10);
        chk("rstmid_idle", 32'(aguardando), 32'h0);

        // Randomized handshakes with short bounces ahead of the real press
        for (int n = 0; n < 8; n++) begin
            pedido  = 1'b1;
            dadosIN = 8'($urandom_range(0, 255));
            tick($urandom_range(1, 5));
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                chave = 1'b0;
                tick($urandom_range(1, DEB - 1));
                chave = 1'b1;
                tick($urandom_range(1, 3));
            end
            press_expect("random");
            if ($urandom_range(0, 1) == 1) begin
                chave = 1'b1;
                tick($urandom_range(1, 8));
                pedido = 1'b0;
            end else begin
                pedido = 1'b0;
                tick($urandom_range(1, 8));
                chave = 1'b1;
            end
            tick(8);
            chk("random_back_idle", 32'(aguardando), 32'h0);
            chk("random_dado_held", dado, last_dado);
        end

        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
